prog_rom_loader: RTL and testbench
==================================

// Module: prog_rom_loader
// PURPOSE
//  Program-memory responder for the 4-bit CPU's instruction fetch port: returns instr[7:0] for the
//  CPU's address[3:0]. Holds a 16x8 writable program store, filled over a byte-wide valid/ready
//  load port. Sequences CPU reset: the CPU is held in reset while loading and released afterwards.
//  Sits between the external loader (test host / boot source) and the CPU's address/instr pins.
// PARAMETERS
//  ADDR_W  4   program address width; DEPTH = 2**ADDR_W entries
//  DATA_W  8   instruction width (opcode[7:4], immediate[3:0])
// PORTS
//  clk          in   1       clock; all state changes on posedge
//  n_reset      in   1       synchronous, active-low reset
//  address      in   ADDR_W  fetch address from the CPU program counter
//  instr        out  DATA_W  instruction for the CPU
//  ld_start     in   1       1-cycle pulse: begin (or restart) a full program load
//  ld_valid     in   1       ld_data holds a valid byte
//  ld_data      in   DATA_W  program byte, delivered in address order from 0
//  ld_ready     out  1       block accepts ld_data this cycle
//  ld_done      out  1       1-cycle pulse: last byte written
//  cpu_n_reset  out  1       drives the CPU n_reset; low = CPU held in reset
//  checksum     out  DATA_W  mod-256 sum of the bytes in the last completed load
// BEHAVIOUR
//  - n_reset low at posedge: state=HALT, all memory words=0x00, wr_ptr=0, sum=0, checksum=0,
//    ld_ready=0, ld_done=0, cpu_n_reset=0. Applies mid-load; the partial load is discarded.
//  - States: HALT -> (ld_start) LOAD -> (last byte accepted) RELEASE -> RUN -> (ld_start) LOAD.
//    No other transitions are legal.
//  - HALT: CPU held in reset; instr=0x00; ld_valid ignored.
//  - LOAD: entry clears wr_ptr and sum; ld_ready=1 for the whole state (registered, high the
//    cycle after ld_start). On ld_valid&&ld_ready: mem[wr_ptr]<=ld_data, sum<=sum+ld_data
//    (8-bit wrap), wr_ptr<=wr_ptr+1. Transfers may be sparse (ld_valid gaps allowed).
//  - Transfer at wr_ptr==DEPTH-1: state->RELEASE, ld_done=1 for exactly that next cycle,
//    checksum<=sum+ld_data, ld_ready=0. wr_ptr wraps to 0.
//  - RELEASE: one cycle with cpu_n_reset still 0, so the CPU samples reset at least once
//    after the load. Then state->RUN.
//  - RUN: cpu_n_reset=1. instr=mem[address] is a combinational async read with zero latency.
//    The CPU uses instr in the same cycle its PC presents address.
//  - Outside RUN, instr=0x00 regardless of address.
//  - ld_start in LOAD: restart at wr_ptr=0, sum=0; already-written words are kept until overwritten.
//  - ld_start in RUN: cpu_n_reset drops to 0 on the next posedge, then LOAD as above.
//  - ld_start and a valid transfer in the same LOAD cycle: restart wins; the byte is dropped.
//  - ld_start in RELEASE: ignored.
//  - ld_valid outside LOAD: ignored, with no memory write.
//  - cpu_n_reset, ld_ready, ld_done are registered outputs (glitch-free into the CPU).
//  - The memory contents survive RUN->LOAD restarts. Only n_reset clears the memory.
// STRUCTURE
//  - Shared package/include: state encodings (HALT=2'd0, LOAD=2'd1, RELEASE=2'd2, RUN=2'd3),
//    ADDR_W/DATA_W defaults, and the CPU opcode constants used by the benches to build programs.
//  - One sub-module, prog_mem_16x8: sync write port, async read port, synchronous clear.
//  - FSM, write pointer, checksum and reset sequencing stay in the top module.
// TESTING
//  1. Reset, then idle 5 cycles -> cpu_n_reset=0, ld_ready=0, instr=0x00 for any address.
//  2. ld_start, then 16 back-to-back bytes 0x30..0x3F -> ld_done pulse on the cycle after
//     the last transfer, checksum=0x78, one RELEASE cycle, then cpu_n_reset=1.
//     address=5 -> instr=0x35 in the same cycle.
//  3. Load with ld_valid toggling every other cycle -> the same final contents as test 2;
//     no byte is duplicated or skipped.
//  4. ld_start after the 7th byte, then 16 new bytes 0xA0..0xAF -> mem[0..15]=0xA0..0xAF,
//     checksum=0x78 (wrapped).
//  5. Assert n_reset after the 9th byte -> all words read 0x00 after the next load of zeros;
//     state=HALT, cpu_n_reset=0.
//  6. Full system: load "MOV A,1 / OUT A / JMP..." with the CPU attached, in RUN ->
//     CPU out port shows 4'h1 within 3 cycles.
//     Then ld_start from RUN -> CPU is reset before the next program is fetched.

Source files
------------

// File: rtl/prog_rom_loader_pkg.sv
// Shared types and constants for the program-ROM loader and the 4-bit CPU programs it serves.
package prog_rom_loader_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // CPU opcodes live in instr[7:4]; instr[3:0] is the immediate.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV_A = 4'h1;
  localparam logic [3:0] OP_OUT_A = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;

  function automatic logic [7:0] mk_instr(input logic [3:0] op, input logic [3:0] imm);
    return {op, imm};
  endfunction
endpackage

// File: rtl/prog_mem_16x8.sv
// Program store: one synchronous write port, one asynchronous read port, synchronous clear.
module prog_mem_16x8 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prog_rom_loader.sv
// Fetch responder for the 4-bit CPU: loads the program store over a byte port and sequences CPU reset.
module prog_rom_loader
  import prog_rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instr,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              cpu_n_reset,
  output logic [DATA_W-1:0] checksum,
  output state_e            dbg_state
);
  // Load port: a byte moves when ld_valid && ld_ready are both high at a posedge.
  // ld_ready is high for the whole LOAD state; a same-cycle ld_start drops the byte.
  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] checksum_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              cpu_n_reset_q;

  logic              xfer;
  logic              mem_we;
  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] rd_data;

  assign xfer   = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
  assign mem_we = xfer && !ld_start;
  assign sum_d  = sum_q + ld_data;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= ST_HALT;
      wr_ptr_q      <= '0;
      sum_q         <= '0;
      checksum_q    <= '0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      cpu_n_reset_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (ld_start) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            ld_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_start) begin
            wr_ptr_q <= '0;
            sum_q    <= '0;
          end else if (xfer) begin
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (&wr_ptr_q) begin
              state_q    <= ST_RELEASE;
              ld_done_q  <= 1'b1;
              checksum_q <= sum_d;
              ld_ready_q <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          // CPU has seen reset at least once after the final write; let it go now.
          state_q       <= ST_RUN;
          cpu_n_reset_q <= 1'b1;
        end
        ST_RUN: begin
          if (ld_start) begin
            state_q       <= ST_LOAD;
            cpu_n_reset_q <= 1'b0;
            wr_ptr_q      <= '0;
            sum_q         <= '0;
            ld_ready_q    <= 1'b1;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  prog_mem_16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk     (clk),
    .n_reset (n_reset),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ld_data),
    .raddr_i (address),
    .rdata_o (rd_data)
  );

  assign instr       = (state_q == ST_RUN) ? rd_data : '0;
  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign checksum    = checksum_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_prog_rom_loader.sv
// Bench for prog_rom_loader: vector table, directed load sequences, random traffic, attached CPU.
module tb_prog_rom_loader;
  import prog_rom_loader_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] address;
  logic [7:0] instr;
  logic       ld_start, ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready, ld_done, cpu_n_reset;
  logic [7:0] checksum;
  state_e     dbg_state;

  logic       cpu_attached = 1'b0;
  logic [3:0] tb_addr;
  logic [3:0] cpu_pc, cpu_a, cpu_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign address = cpu_attached ? cpu_pc : tb_addr;

  prog_rom_loader dut (
    .clk(clk), .n_reset(n_reset), .address(address), .instr(instr),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .cpu_n_reset(cpu_n_reset),
    .checksum(checksum), .dbg_state(dbg_state)
  );

  // Minimal 4-bit CPU: executes instr at its PC every cycle it is out of reset.
  always @(posedge clk) begin
    if (!cpu_n_reset) begin
      cpu_pc <= 4'h0; cpu_a <= 4'h0; cpu_out <= 4'h0;
    end else begin
      case (instr[7:4])
        OP_MOV_A: begin cpu_a <= instr[3:0]; cpu_pc <= cpu_pc + 4'h1; end
        OP_OUT_A: begin cpu_out <= cpu_a;    cpu_pc <= cpu_pc + 4'h1; end
        OP_JMP:   cpu_pc <= instr[3:0];
        default:  cpu_pc <= cpu_pc + 4'h1;
      endcase
    end
  end

  // Reference model: contents, phase flags and running sums straight from the behaviour rules.
  logic [7:0] m_mem [16];
  int         m_ptr;
  int         m_sum;
  logic [7:0] m_chk;
  bit         m_loading, m_releasing, m_running, m_done;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 0; m_sum = 0; m_chk = 8'h00;
    m_loading = 0; m_releasing = 0; m_running = 0; m_done = 0;
  endtask

  task automatic model_update(input bit nrst, input bit st, input bit vl, input logic [7:0] d);
    m_done = 0;
    if (!nrst) begin
      model_reset();
    end else if (m_loading) begin
      if (st) begin
        m_ptr = 0; m_sum = 0;
      end else if (vl) begin
        m_mem[m_ptr] = d;
        m_sum = (m_sum + int'(d)) % 256;
        if (m_ptr == 15) begin
          m_chk = 8'(m_sum); m_loading = 0; m_releasing = 1; m_done = 1; m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end
    end else if (m_releasing) begin
      m_releasing = 0; m_running = 1;
    end else if (m_running) begin
      if (st) begin
        m_running = 0; m_loading = 1; m_ptr = 0; m_sum = 0;
      end
    end else if (st) begin
      m_loading = 1; m_ptr = 0; m_sum = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int exp_state;
    exp_state = m_running ? 3 : (m_releasing ? 2 : (m_loading ? 1 : 0));
    check("ld_ready", 32'(ld_ready), 32'(m_loading));
    check("ld_done", 32'(ld_done), 32'(m_done));
    check("cpu_n_reset", 32'(cpu_n_reset), 32'(m_running));
    check("instr", 32'(instr), m_running ? 32'(m_mem[address]) : 32'h0);
    check("checksum", 32'(checksum), 32'(m_chk));
    check("state", 32'(dbg_state), 32'(exp_state));
  endtask

  // One clock: drive at the negedge, compare before the posedge, advance the model with it.
  task automatic drive(input bit nrst, input bit st, input bit vl, input logic [7:0] d,
                       input logic [3:0] a);
    n_reset = nrst; ld_start = st; ld_valid = vl; ld_data = d; tb_addr = a;
    #1;
    compare_all();
    @(posedge clk);
    model_update(nrst, st, vl, d);
    @(negedge clk);
  endtask

  logic [7:0] img [16];

  task automatic load_img(input bit gap);
    drive(1, 1, 0, 8'h00, 4'(($urandom)));
    for (int k = 0; k < 16; k++) begin
      if (gap) drive(1, 0, 0, 8'($urandom), 4'($urandom));
      drive(1, 0, 1, img[k], 4'($urandom));
    end
    check("ld_done_pulse", 32'(ld_done), 32'h1);
    check("cpu_held_in_release", 32'(cpu_n_reset), 32'h0);
    drive(1, 0, 0, 8'h00, 4'h0);
    check("cpu_released", 32'(cpu_n_reset), 32'h1);
    check("ld_done_single", 32'(ld_done), 32'h0);
  endtask

  task automatic check_contents(input string name, input logic [7:0] base, input logic [7:0] step);
    for (int a = 0; a < 16; a++) begin
      tb_addr = 4'(a);
      #1;
      check(name, 32'(instr), 32'(8'(base + 8'(a) * step)));
    end
  endtask

  typedef struct {
    bit         st;
    bit         vl;
    logic [7:0] d;
    logic [3:0] a;
    bit         e_ready;
    bit         e_done;
    bit         e_cpu;
    logic [7:0] e_instr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit found;

    // HALT ignores ld_valid; start, write, restart dropping its byte, write again.
    vecs[0] = '{0, 1, 8'h55, 4'h3, 0, 0, 0, 8'h00};
    vecs[1] = '{1, 0, 8'h00, 4'h5, 0, 0, 0, 8'h00};
    vecs[2] = '{0, 1, 8'h11, 4'h0, 1, 0, 0, 8'h00};
    vecs[3] = '{0, 0, 8'h99, 4'h0, 1, 0, 0, 8'h00};
    vecs[4] = '{1, 1, 8'h22, 4'h1, 1, 0, 0, 8'h00};
    vecs[5] = '{0, 1, 8'h33, 4'h2, 1, 0, 0, 8'h00};

    n_reset = 0; ld_start = 0; ld_valid = 0; ld_data = 8'h00; tb_addr = 4'h0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // Idle after reset: CPU held, nothing ready, instr zero.
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 8'($urandom), 4'($urandom));
    check("idle_cpu_n_reset", 32'(cpu_n_reset), 32'h0);

    for (int i = 0; i < 6; i++) begin
      n_reset = 1; ld_start = vecs[i].st; ld_valid = vecs[i].vl;
      ld_data = vecs[i].d; tb_addr = vecs[i].a;
      #1;
      check("vec_ready", 32'(ld_ready), 32'(vecs[i].e_ready));
      check("vec_done", 32'(ld_done), 32'(vecs[i].e_done));
      check("vec_cpu", 32'(cpu_n_reset), 32'(vecs[i].e_cpu));
      check("vec_instr", 32'(instr), 32'(vecs[i].e_instr));
      @(posedge clk);
      model_update(1, vecs[i].st, vecs[i].vl, vecs[i].d);
      @(negedge clk);
    end

    // Back-to-back 0x30..0x3F.
    for (int k = 0; k < 16; k++) img[k] = 8'h30 + 8'(k);
    load_img(0);
    check("checksum_30", 32'(checksum), 32'h78);
    tb_addr = 4'h5;
    #1;
    check("instr_addr5", 32'(instr), 32'h35);
    check_contents("contents_30", 8'h30, 8'h01);

    // Same bytes with ld_valid gaps.
    load_img(1);
    check("checksum_gap", 32'(checksum), 32'h78);
    check_contents("contents_gap", 8'h30, 8'h01);

    // Restart after the 7th byte, then 0xA0..0xAF.
    drive(1, 1, 0, 8'h00, 4'h0);
    for (int k = 0; k < 7; k++) drive(1, 0, 1, 8'h55, 4'h0);
    for (int k = 0; k < 16; k++) img[k] = 8'hA0 + 8'(k);
    load_img(0);
    check("checksum_a0", 32'(checksum), 32'h78);
    check_contents("contents_a0", 8'hA0, 8'h01);

    // Reset after the 9th byte, then a load of zeros.
    drive(1, 1, 0, 8'h00, 4'h0);
    for (int k = 0; k < 9; k++) drive(1, 0, 1, 8'h77, 4'h0);
    drive(0, 0, 1, 8'h77, 4'h0);
    check("reset_state_halt", 32'(dbg_state), 32'(ST_HALT));
    check("reset_cpu_held", 32'(cpu_n_reset), 32'h0);
    check("reset_checksum", 32'(checksum), 32'h0);
    for (int k = 0; k < 16; k++) img[k] = 8'h00;
    load_img(0);
    check_contents("contents_zero", 8'h00, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 2) != 0), 8'($urandom), 4'($urandom));
    end

    // CPU attached: MOV A,1 / OUT A / JMP 2.
    cpu_attached = 1'b1;
    for (int k = 0; k < 16; k++) img[k] = mk_instr(OP_NOP, 4'h0);
    img[0] = mk_instr(OP_MOV_A, 4'h1);
    img[1] = mk_instr(OP_OUT_A, 4'h0);
    img[2] = mk_instr(OP_JMP, 4'h2);
    load_img(0);
    check("cpu_pc_at_run", 32'(cpu_pc), 32'h0);
    found = 0;
    for (int c = 0; c < 3 && !found; c++) begin
      drive(1, 0, 0, 8'h00, 4'h0);
      if (cpu_out == 4'h1) found = 1;
    end
    check("cpu_out_1", 32'(cpu_out), 32'h1);

    // Reload from RUN: the CPU must be reset before fetching the new program.
    drive(1, 1, 0, 8'h00, 4'h0);
    check("reload_cpu_reset", 32'(cpu_n_reset), 32'h0);
    check("reload_ready", 32'(ld_ready), 32'h1);
    img[0] = mk_instr(OP_MOV_A, 4'h5);
    load_img(0);
    check("cpu_pc_after_reload", 32'(cpu_pc), 32'h0);
    check("cpu_out_cleared", 32'(cpu_out), 32'h0);
    found = 0;
    for (int c = 0; c < 3 && !found; c++) begin
      drive(1, 0, 0, 8'h00, 4'h0);
      if (cpu_out == 4'h5) found = 1;
    end
    check("cpu_out_5", 32'(cpu_out), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
